mem_frame_reader: RTL
=====================

# mem_frame_reader

Streams one frame of words out of the inferred single-port image RAM, in address order, as a valid/ready stream. It sits on the read side of the image memory: it owns the RAM address bus while busy and absorbs the RAM's one-cycle read latency with a 2-entry prefetch buffer, so it sustains one word per clock when the sink never stalls. Writers to the RAM must not drive the address while `busy` is high.

## Interface
- `RAM_WIDTH`, 24, data word width; must match the RAM.
- `RAM_ADDR_BITS`, 10, RAM address width.
- `FRAME_LEN`, 1024, words per frame; legal range 1..2**RAM_ADDR_BITS.

- `clk` in 1: single clock; all flops on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request one frame; sampled only in IDLE.
- `busy` out 1: high from the edge after `start` is accepted until the edge that returns to IDLE.
- `done` out 1: one-cycle pulse when the frame's last word is accepted.
- `mem_addr` out RAM_ADDR_BITS: RAM address; drives the RAM `addr` input directly.
- `mem_do` in RAM_WIDTH: RAM `DO`, valid one cycle after the address edge.
- `m_data` out RAM_WIDTH: stream data, the head of the prefetch buffer.
- `m_valid` out 1: stream valid.
- `m_ready` in 1: sink ready; a transfer occurs when `m_valid && m_ready` at a rising edge.
- `m_last` out 1: high with the frame's final word (address FRAME_LEN-1).

## Operation
- States: IDLE and RUN.
  - IDLE → RUN on `start`.
  - RUN → IDLE on the transfer of the last word (non-loop build).
- Reset values: state IDLE, `mem_addr` 0, issue count 0, in-flight flag 0, buffer empty. All outputs are 0: `busy`, `done`, `m_valid`, `m_last` and `m_data`.
- Read issue:
  - A read is issued in a RUN cycle when all of the following hold:
    - issue count < FRAME_LEN;
    - occupancy + inflight − pop < 2, where pop = `m_valid && m_ready`.
  - On issue, the RAM samples `mem_addr` at that edge. `mem_addr` then increments and the issue count increments.
- Data capture: on the edge after an issue, `mem_do` is written into the buffer tail. The in-flight flag tracks this one outstanding read.
- Buffer: 2-entry FIFO. A push and a pop in the same cycle are both honoured. The buffer never overflows because of the issue rule above.
- `m_data` and `m_valid` are held stable while `m_valid && !m_ready`.
- `m_last` is a tag stored alongside each entry. It is set for the entry whose address was FRAME_LEN-1.
- `mem_addr` wraps: with FRAME_LEN = 2**RAM_ADDR_BITS, `mem_addr` rolls to 0 after the last issue, and no further issue occurs.
- `start` while RUN is ignored, except in the loop build (see Configuration).
- Asynchronous reset mid-frame: everything returns immediately to reset values. Buffered words are discarded, and no `done` pulse is produced.

## Timing
- `start` high at edge E0 (IDLE) → RUN and `busy` high after E0.
- First issue at E1 (`mem_addr`=0 sampled). Word 0 is written to the buffer at E2, so `m_valid` is high after E2.
- Latency from `start` to first `m_valid` is therefore 2 cycles.
- With `m_ready` held high, one word transfers per cycle. Word k transfers at edge E(3+k).
- A frame takes FRAME_LEN+2 cycles from `start` to the final transfer.
- `done` is high for the cycle following the last transfer edge. `busy` falls on that same edge.
- `m_ready` low: at most 2 words are buffered and issue pauses. Issue resumes the cycle that pop allows, with no bubble on resume.
- `mem_addr` changes only on edges and only on issue.

## Configuration
- `MFR_LOOP_EN` defined:
  - If `start` is high on the last-word transfer edge, the block stays in RUN and restarts issue at address 0 with no gap cycle.
  - `done` still pulses once per frame and `busy` stays high.
  - Prefetch of the next frame's word 0 may begin before the last-word transfer, once the issue count reaches FRAME_LEN and `start` is high.
- `MFR_LOOP_EN` undefined:
  - The block always returns to IDLE after the last transfer.
  - A new `start` is accepted no earlier than the cycle after `done`.

## Test plan
- RAM preloaded with word value = address, FRAME_LEN=8, `m_ready`=1, `start` pulsed:
  - stream is 0..7 on consecutive cycles, first `m_valid` 2 cycles after `start`;
  - `m_last` is high only on 7;
  - `done` pulses once, 1 cycle after 7's transfer.
- Same frame with `m_ready` toggling 1,0,0,1,...:
  - all 8 words arrive in order with no loss or duplication;
  - `m_data` is stable across every stall;
  - `mem_addr` never runs more than 2 ahead of the accepted count.
- FRAME_LEN=1024 at RAM_ADDR_BITS=10:
  - words 0..1023 are delivered;
  - `mem_addr` wraps to 0 and no 1025th read is issued.
- `rst_n` asserted after word 3 transfers: outputs are 0 immediately and there is no `done`. A subsequent `start` delivers from word 0.
- `start` re-asserted mid-frame (non-loop build): ignored and the frame is unchanged. With `MFR_LOOP_EN` and `start` held: two back-to-back frames 0..7,0..7 with no gap cycle and two `done` pulses.
- FRAME_LEN=1: a single word 0 with `m_last`=1, and `done` 1 cycle after its transfer.

Source files
------------

// File: rtl/mem_frame_reader_if.sv
// Start/status handshake, RAM read port and output stream of mem_frame_reader.
// master: the reader; slave: the RAM/sink/controller side.
interface mem_frame_reader_if #(
    parameter int unsigned RAM_WIDTH     = 24,
    parameter int unsigned RAM_ADDR_BITS = 10
) ();
    logic                     start;
    logic                     busy;
    logic                     done;
    logic [RAM_ADDR_BITS-1:0] mem_addr;
    logic [RAM_WIDTH-1:0]     mem_do;
    logic [RAM_WIDTH-1:0]     m_data;
    logic                     m_valid;
    logic                     m_ready;
    logic                     m_last;

    modport master (
        input  start, mem_do, m_ready,
        output busy, done, mem_addr, m_data, m_valid, m_last
    );

    modport slave (
        output start, mem_do, m_ready,
        input  busy, done, mem_addr, m_data, m_valid, m_last
    );
endinterface

// File: rtl/mem_frame_reader.sv
// Streams one frame of RAM words in address order through a 2-entry prefetch buffer.
// Define MFR_LOOP_EN to chain frames back-to-back while start is held high.
module mem_frame_reader #(
    parameter int unsigned RAM_WIDTH     = 24,
    parameter int unsigned RAM_ADDR_BITS = 10,
    parameter int unsigned FRAME_LEN     = 1024
) (
    input logic                clk,
    input logic                rst_n,
    mem_frame_reader_if.master bus
);
    localparam int unsigned     CntW     = RAM_ADDR_BITS + 1;
    localparam logic [CntW-1:0] FrameLen = CntW'(FRAME_LEN);
    localparam logic [CntW-1:0] LastIdx  = CntW'(FRAME_LEN - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e                   state_q;
    logic                     busy_q;
    logic                     done_q;
    logic [RAM_ADDR_BITS-1:0] addr_q;
    logic [CntW-1:0]          cnt_q;
    logic                     inflight_q;
    logic                     inflight_last_q;
    logic [1:0]               occ_q;
    logic [RAM_WIDTH-1:0]     data0_q;
    logic [RAM_WIDTH-1:0]     data1_q;
    logic                     last0_q;
    logic                     last1_q;

    logic            pop;
    logic            push;
    logic            rearm;
    logic            issue;
    logic            issue_last;
    logic            last_pop;
    logic            end_frame;
    logic [2:0]      occ_after;
    logic [CntW-1:0] idx;

`ifdef MFR_LOOP_EN
    assign rearm = bus.start;
`else
    assign rearm = 1'b0;
`endif

    always_comb begin
        pop        = (occ_q != 2'd0) && bus.m_ready;
        push       = inflight_q;
        occ_after  = {1'b0, occ_q} + {2'b00, push} - {2'b00, pop};
        // Once the frame is fully issued, a rearmed issue restarts at word 0.
        idx        = (cnt_q < FrameLen) ? cnt_q : '0;
        issue_last = (idx == LastIdx);
        issue      = (state_q == StRun) && ((cnt_q < FrameLen) || rearm) &&
                     (occ_after < 3'd2);
        last_pop   = pop && last0_q;
        end_frame  = last_pop && !rearm;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            addr_q          <= '0;
            cnt_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            occ_q           <= 2'd0;
            data0_q         <= '0;
            data1_q         <= '0;
            last0_q         <= 1'b0;
            last1_q         <= 1'b0;
        end else begin
            done_q     <= last_pop;
            inflight_q <= issue;
            if (issue) begin
                addr_q          <= issue_last ? '0 : addr_q + 1'b1;
                cnt_q           <= idx + 1'b1;
                inflight_last_q <= issue_last;
            end

            if (push && pop) begin
                if (occ_q == 2'd1) begin
                    data0_q <= bus.mem_do;
                    last0_q <= inflight_last_q;
                end else begin
                    data0_q <= data1_q;
                    last0_q <= last1_q;
                    data1_q <= bus.mem_do;
                    last1_q <= inflight_last_q;
                end
            end else if (push) begin
                if (occ_q == 2'd0) begin
                    data0_q <= bus.mem_do;
                    last0_q <= inflight_last_q;
                end else begin
                    data1_q <= bus.mem_do;
                    last1_q <= inflight_last_q;
                end
                occ_q <= occ_q + 2'd1;
            end else if (pop) begin
                data0_q <= data1_q;
                last0_q <= last1_q;
                occ_q   <= occ_q - 2'd1;
            end

            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_q <= StRun;
                        busy_q  <= 1'b1;
                    end
                end
                StRun: begin
                    // Leaving RUN drops any prefetched words of an abandoned next frame.
                    if (end_frame) begin
                        state_q    <= StIdle;
                        busy_q     <= 1'b0;
                        cnt_q      <= '0;
                        addr_q     <= '0;
                        occ_q      <= 2'd0;
                        inflight_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.mem_addr = addr_q;
    assign bus.m_data   = data0_q;
    assign bus.m_valid  = (occ_q != 2'd0);
    assign bus.m_last   = (occ_q != 2'd0) && last0_q;
endmodule
